// File: rtl/spi_host_ctrl.sv
// -----------------------------------------------------------------------------
// spi_host_ctrl
//   SPI initiator (mode 0) for the chip's configuration/readback port.
//   Each frame is a single full-duplex shift of FRAME_W bits, MSB first:
//   TX_DATA is shifted out on MOSI while MISO is shifted into RX_DATA.
//   SCLK idles low, MOSI changes on SCLK fall, both ends sample on SCLK rise.
//
// Parameters
//   FRAME_W   bits per frame (>=2)
//   DIV       clk cycles per SCLK half-period (>=1)
//   CS_SETUP  clk cycles from CEB fall to first SCLK rise, counted as
//             setup + first low phase (>=1)
//   CS_HOLD   clk cycles from last SCLK fall to CEB rise (>=1)
//
// Ports
//   clk      in   system clock, all logic on posedge
//   rst      in   synchronous reset, active-high
//   start    in   frame request, sampled only while idle
//   tx_data  in   frame to send, latched when start is accepted
//   busy     out  frame in progress
//   done     out  one-cycle pulse, frame complete and rx_data valid
//   rx_data  out  captured MISO bits, MSB = first bit received
//   ceb      out  chip enable, active-low
//   sclk     out  serial clock
//   mosi     out  serial data out
//   miso     in   serial data in (sampled unsynchronised; DIV>=2 advised)
// -----------------------------------------------------------------------------
module spi_host_ctrl #(
    parameter int FRAME_W  = 64,
    parameter int DIV      = 4,
    parameter int CS_SETUP = 2,
    parameter int CS_HOLD  = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [FRAME_W-1:0] tx_data,
    output logic               busy,
    output logic               done,
    output logic [FRAME_W-1:0] rx_data,
    output logic               ceb,
    output logic               sclk,
    output logic               mosi,
    input  logic               miso
);

    // One phase counter serves the setup, low, high and hold phases, so it
    // is sized for the longest of them.
    localparam int PH_MAX = (DIV > CS_SETUP)
                          ? ((DIV > CS_HOLD) ? DIV : CS_HOLD)
                          : ((CS_SETUP > CS_HOLD) ? CS_SETUP : CS_HOLD);
    localparam int PH_W   = $clog2(PH_MAX + 1);
    localparam int BIT_W  = $clog2(FRAME_W + 1);

    // Terminal counts; each phase lasts (last + 1) cycles.
    localparam logic [PH_W-1:0]  DIV_LAST   = PH_W'(DIV - 1);
    localparam logic [PH_W-1:0]  SETUP_LAST = PH_W'(CS_SETUP - 2);
    localparam logic [PH_W-1:0]  HOLD_LAST  = PH_W'(CS_HOLD - 1);
    localparam logic [BIT_W-1:0] BIT_LAST   = BIT_W'(FRAME_W);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_LOW,
        ST_HIGH,
        ST_HOLD
    } state_t;

    state_t             state;
    logic [PH_W-1:0]    ph_cnt;
    logic [BIT_W-1:0]   bit_cnt;
    // Only the bits not yet driven onto MOSI; the MSB goes out straight
    // from tx_data when the frame is accepted.
    logic [FRAME_W-2:0] tx_sr;
    logic [FRAME_W-1:0] rx_sr;

    // NOTE: every register here is assigned with <= so all of them update
    // together from pre-edge values; mixing in = would make the result depend
    // on statement order.
    always_ff @(posedge clk) begin
        // NOTE: reset is synchronous and reloads every register, including
        // the shift registers, so an aborted frame leaves nothing behind.
        if (rst) begin
            state   <= ST_IDLE;
            ph_cnt  <= '0;
            bit_cnt <= '0;
            tx_sr   <= '0;
            rx_sr   <= '0;
            ceb     <= 1'b1;
            sclk    <= 1'b0;
            mosi    <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            rx_data <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        tx_sr   <= tx_data[FRAME_W-2:0];
                        rx_sr   <= '0;
                        ceb     <= 1'b0;
                        mosi    <= tx_data[FRAME_W-1];
                        busy    <= 1'b1;
                        bit_cnt <= '0;
                        ph_cnt  <= '0;
                        // With a one-cycle setup the first low phase already
                        // provides all the CEB-to-SCLK setup there is.
                        state   <= (CS_SETUP == 1) ? ST_LOW : ST_SETUP;
                    end
                end

                ST_SETUP: begin
                    if (ph_cnt == SETUP_LAST) begin
                        ph_cnt <= '0;
                        state  <= ST_LOW;
                    end else begin
                        ph_cnt <= ph_cnt + 1'b1;
                    end
                end

                ST_LOW: begin
                    if (ph_cnt == DIV_LAST) begin
                        ph_cnt  <= '0;
                        sclk    <= 1'b1;
                        // Capture on the same edge that raises SCLK; the
                        // target drove MISO on the previous fall.
                        rx_sr   <= {rx_sr[FRAME_W-2:0], miso};
                        bit_cnt <= bit_cnt + 1'b1;
                        state   <= ST_HIGH;
                    end else begin
                        ph_cnt <= ph_cnt + 1'b1;
                    end
                end

                ST_HIGH: begin
                    if (ph_cnt == DIV_LAST) begin
                        ph_cnt <= '0;
                        sclk   <= 1'b0;
                        if (bit_cnt == BIT_LAST) begin
                            mosi  <= 1'b0;
                            state <= ST_HOLD;
                        end else begin
                            mosi  <= tx_sr[FRAME_W-2];
                            tx_sr <= tx_sr << 1;
                            state <= ST_LOW;
                        end
                    end else begin
                        ph_cnt <= ph_cnt + 1'b1;
                    end
                end

                ST_HOLD: begin
                    if (ph_cnt == HOLD_LAST) begin
                        ph_cnt  <= '0;
                        ceb     <= 1'b1;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        rx_data <= rx_sr;
                        state   <= ST_IDLE;
                    end else begin
                        ph_cnt <= ph_cnt + 1'b1;
                    end
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_host_ctrl.sv
// -----------------------------------------------------------------------------
// tb_spi_host_ctrl
//   Two instances: a default-parameter initiator talking to a behavioural
//   mode-0 target (or looped back), and a minimal 8-bit / DIV=1 instance in
//   loopback. Stimulus pushes expected frames into per-instance queues; a
//   monitor on each instance pops and compares whenever DONE is seen.
// -----------------------------------------------------------------------------
module tb_spi_host_ctrl;

    localparam int FW    = 64;
    localparam int DIV   = 4;
    localparam int CSS   = 2;
    localparam int CSH   = 2;
    localparam int A_LOW = CSS - 1 + 2 * DIV * FW + CSH;   // 515

    localparam int FWB   = 8;
    localparam int B_LOW = 0 + 2 * 1 * FWB + 1;             // 17

    typedef enum logic [1:0] {M_LOOP, M_SLAVE, M_FORCE} miso_mode_t;

    typedef struct {
        logic [63:0] tx;
        logic [63:0] rx;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst = 1'b1;

    // instance A
    logic          start_a = 1'b0;
    logic [FW-1:0] tx_a = '0;
    logic          busy_a, done_a, ceb_a, sclk_a, mosi_a, miso_a;
    logic [FW-1:0] rx_a;

    // instance B
    logic           start_b = 1'b0;
    logic [FWB-1:0] tx_b = '0;
    logic           busy_b, done_b, ceb_b, sclk_b, mosi_b;
    logic [FWB-1:0] rx_b;

    miso_mode_t mode = M_FORCE;
    logic       miso_force = 1'b0;
    logic       miso_sl = 1'b0;

    assign miso_a = (mode == M_LOOP)  ? mosi_a :
                    (mode == M_SLAVE) ? miso_sl : miso_force;

    spi_host_ctrl #(.FRAME_W(FW), .DIV(DIV), .CS_SETUP(CSS), .CS_HOLD(CSH)) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .tx_data(tx_a),
        .busy(busy_a), .done(done_a), .rx_data(rx_a),
        .ceb(ceb_a), .sclk(sclk_a), .mosi(mosi_a), .miso(miso_a)
    );

    spi_host_ctrl #(.FRAME_W(FWB), .DIV(1), .CS_SETUP(1), .CS_HOLD(1)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .tx_data(tx_b),
        .busy(busy_b), .done(done_b), .rx_data(rx_b),
        .ceb(ceb_b), .sclk(sclk_b), .mosi(mosi_b), .miso(mosi_b)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    exp_t sb_a[$];
    exp_t sb_b[$];

    // ---------------- behavioural mode-0 target on instance A ----------------
    logic [63:0] sl_word = '0;
    logic [63:0] sl_sr   = '0;
    logic [63:0] sl_rx   = '0;
    int          sl_rises = 0;

    always @(negedge ceb_a) begin
        sl_sr    = sl_word;
        miso_sl  = sl_word[63];
        sl_rx    = '0;
        sl_rises = 0;
    end

    always @(posedge sclk_a) begin
        if (ceb_a === 1'b0) begin
            sl_rx = {sl_rx[62:0], mosi_a};
            sl_rises++;
        end
    end

    always @(negedge sclk_a) begin
        if (ceb_a === 1'b0) begin
            sl_sr   = sl_sr << 1;
            miso_sl = sl_sr[63];
        end
    end

    // ---------------- monitor A ----------------
    int   low_run_a = 0;
    int   viol_a = 0;
    logic prev_mosi_a = 1'b0;
    logic prev_done_a = 1'b0;
    exp_t e_a;

    always @(negedge clk) begin
        if (rst) begin
            low_run_a   = 0;
            viol_a      = 0;
            prev_mosi_a = 1'b0;
            prev_done_a = 1'b0;
        end else begin
            // MOSI may only move while SCLK is low.
            if (sclk_a && (mosi_a !== prev_mosi_a)) viol_a++;
            prev_mosi_a = mosi_a;
            if (done_a) begin
                check("a_done_expected", 64'(sb_a.size() > 0), 64'd1);
                if (sb_a.size() > 0) begin
                    e_a = sb_a.pop_front();
                    check("a_rx_data", rx_a, e_a.rx);
                    check("a_mosi_bits", sl_rx, e_a.tx);
                    check("a_sclk_rises", 64'(sl_rises), 64'(FW));
                    check("a_ceb_low_cycles", 64'(low_run_a), 64'(A_LOW));
                    check("a_ceb_high_at_done", 64'(ceb_a), 64'd1);
                    check("a_mosi_stable", 64'(viol_a), 64'd0);
                    check("a_done_single", 64'(prev_done_a), 64'd0);
                end
                low_run_a = 0;
                viol_a    = 0;
            end else if (!ceb_a) begin
                low_run_a++;
            end
            prev_done_a = done_a;
        end
    end

    // ---------------- monitor B ----------------
    int   low_run_b = 0;
    int   rises_b = 0;
    int   since_rise_b = 0;
    int   per_bad_b = 0;
    logic prev_sclk_b = 1'b0;
    exp_t e_b;

    always @(negedge clk) begin
        if (rst) begin
            low_run_b    = 0;
            rises_b      = 0;
            since_rise_b = 0;
            per_bad_b    = 0;
            prev_sclk_b  = 1'b0;
        end else begin
            if (sclk_b && !prev_sclk_b) begin
                rises_b++;
                if (rises_b > 1 && since_rise_b != 2) per_bad_b++;
                since_rise_b = 0;
            end
            since_rise_b++;
            prev_sclk_b = sclk_b;
            if (done_b) begin
                check("b_done_expected", 64'(sb_b.size() > 0), 64'd1);
                if (sb_b.size() > 0) begin
                    e_b = sb_b.pop_front();
                    check("b_rx_data", 64'(rx_b), e_b.rx);
                    check("b_sclk_rises", 64'(rises_b), 64'(FWB));
                    check("b_ceb_low_cycles", 64'(low_run_b), 64'(B_LOW));
                    check("b_sclk_period", 64'(per_bad_b), 64'd0);
                end
                low_run_b = 0;
                rises_b   = 0;
                per_bad_b = 0;
            end else if (!ceb_b) begin
                low_run_b++;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    function automatic logic [63:0] rand64();
        return {$urandom, $urandom};
    endfunction

    task automatic send_a(input logic [63:0] tx, input logic [63:0] rdw, input bit loop);
        exp_t e;
        @(negedge clk);
        mode    = loop ? M_LOOP : M_SLAVE;
        sl_word = rdw;
        tx_a    = tx;
        start_a = 1'b1;
        e.tx = tx;
        e.rx = loop ? tx : rdw;
        sb_a.push_back(e);
        @(negedge clk);
        start_a = 1'b0;
        tx_a    = rand64();
    endtask

    task automatic wait_idle_a(input int max_cyc);
        int n = 0;
        while ((busy_a || sb_a.size() != 0) && n < max_cyc) begin
            @(negedge clk);
            n++;
        end
        check("a_frame_finished", 64'(busy_a || sb_a.size() != 0), 64'd0);
    endtask

    task automatic send_b(input logic [7:0] tx);
        exp_t e;
        @(negedge clk);
        tx_b    = tx;
        start_b = 1'b1;
        e.tx = 64'(tx);
        e.rx = 64'(tx);
        sb_b.push_back(e);
        @(negedge clk);
        start_b = 1'b0;
        tx_b    = 8'($urandom);
    endtask

    task automatic wait_idle_b(input int max_cyc);
        int n = 0;
        while ((busy_b || sb_b.size() != 0) && n < max_cyc) begin
            @(negedge clk);
            n++;
        end
        check("b_frame_finished", 64'(busy_b || sb_b.size() != 0), 64'd0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        logic [63:0] tx1, tx2, rdw;
        int n;

        // Reset held 3 cycles while START and MISO toggle.
        rst = 1'b1;
        tx_a = rand64();
        tx_b = 8'($urandom);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check("rst_ceb", 64'(ceb_a), 64'd1);
            check("rst_sclk", 64'(sclk_a), 64'd0);
            check("rst_mosi", 64'(mosi_a), 64'd0);
            check("rst_busy", 64'(busy_a), 64'd0);
            check("rst_done", 64'(done_a), 64'd0);
            check("rst_rx_data", rx_a, 64'd0);
            check("rst_b_ceb_busy", 64'({ceb_b, busy_b, sclk_b}), 64'b100);
            start_a    = ~start_a;
            start_b    = start_a;
            miso_force = ~miso_force;
        end
        @(negedge clk);
        rst     = 1'b0;
        start_a = 1'b0;
        start_b = 1'b0;

        // Loopback, known pattern.
        send_a(64'hDEADBEEF_01234567, 64'd0, 1'b1);
        wait_idle_a(2000);

        // Target returning a readback chain with 16'h55AA in bits 31:16.
        rdw = rand64();
        rdw[31:16] = 16'h55AA;
        send_a(rand64(), rdw, 1'b0);
        wait_idle_a(2000);
        check("a_readback_field", 64'(rx_a[31:16]), 64'h55AA);

        // Random frames; START pulses while busy must be ignored.
        for (int f = 0; f < 4; f++) begin
            send_a(rand64(), rand64(), f[0]);
            repeat (50 + $urandom_range(0, 300)) @(negedge clk);
            start_a = 1'b1;
            tx_a    = rand64();
            repeat ($urandom_range(1, 4)) @(negedge clk);
            start_a = 1'b0;
            wait_idle_a(2000);
        end

        // START held through a frame: two frames back-to-back, second one
        // using TX_DATA present in the DONE cycle.
        @(negedge clk);
        mode    = M_LOOP;
        tx1     = rand64();
        tx_a    = tx1;
        start_a = 1'b1;
        sb_a.push_back('{tx1, tx1});
        @(negedge clk);
        tx2  = rand64();
        tx_a = tx2;
        sb_a.push_back('{tx2, tx2});
        n = 0;
        while (!done_a && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("b2b_first_done", 64'(done_a), 64'd1);
        @(negedge clk);
        start_a = 1'b0;
        tx_a    = rand64();
        check("b2b_ceb_gap", 64'(ceb_a), 64'd0);
        check("b2b_second_busy", 64'(busy_a), 64'd1);
        wait_idle_a(2000);
        repeat (10) @(negedge clk);
        check("b2b_no_third", 64'({ceb_a, busy_a}), 64'b10);

        // Reset after the 20th SCLK rise aborts the frame.
        send_a(rand64(), 64'd0, 1'b1);
        n = 0;
        while (sl_rises != 20 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("abort_reached_rise20", 64'(sl_rises), 64'd20);
        rst = 1'b1;
        sb_a.delete();
        @(posedge clk);
        #1;
        check("abort_ceb", 64'(ceb_a), 64'd1);
        check("abort_sclk", 64'(sclk_a), 64'd0);
        check("abort_busy", 64'(busy_a), 64'd0);
        check("abort_done", 64'(done_a), 64'd0);
        check("abort_rx_data", rx_a, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (600) @(negedge clk);
        check("abort_rx_kept", rx_a, 64'd0);
        check("abort_idle", 64'({ceb_a, busy_a}), 64'b10);
        send_a(rand64(), rand64(), 1'b0);
        wait_idle_a(2000);

        // Minimal instance: 8-bit frames, DIV=1, one-cycle setup/hold.
        send_b(8'hA5);
        wait_idle_b(200);
        for (int f = 0; f < 5; f++) begin
            send_b(8'($urandom));
            wait_idle_b(200);
        end
        check("b_last_idle", 64'({ceb_b, busy_b}), 64'b10);

        repeat (5) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached, got no end expected end");
        $fatal(1, "watchdog");
    end

endmodule
